mura_driver: RTL and testbench

Sequencer and checker for the three-state Moore counter (gray-coded S0=00, S1=01, S2=11; advances on `a`=1 when `en` is high). It takes a bit pattern from a host and plays it into the counter as paced `en`/`a` steps. It runs a cycle-exact model of the counter and compares the counter's registered `y` against the model after every step. It sits between a host/test controller and one counter instance, and that counter shares this block's `clk` and `rst_n`.

---
 rtl/mura_driver.sv | 126 ++++++++++++
 tb/tb_mura_driver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mura_driver.sv
// mura_driver: plays a bit pattern into a gray-coded 3-state Moore counter as paced en/a steps
// and checks the counter's registered y against a cycle-exact model after every step.
module mura_driver #(
    parameter int PAT_W    = 8,
    parameter int STEP_DIV = 4,
    parameter int LEN_W    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             y_in,
    output logic             en,
    output logic             a,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] err_idx,
    output logic [1:0]       model_state
);
    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((STEP_DIV > 2) ? STEP_DIV - 3 : 0);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    typedef enum logic [2:0] {IDLE, STEP, CHECK, GAP, FIN} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d, eidx_q, eidx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ms_q, ms_d;
    logic               a_q, a_d, exp_q, exp_d, err_q, err_d;
    logic [LEN_W-1:0]   len_c, idx_inc;
    logic [1:0]         ms_nxt;
    logic               pat_bit, s0, s1, s2, y_exp;

    assign len_c   = (len > LEN_MAX) ? LEN_MAX : len;
    assign idx_inc = idx_q + 1'b1;
    assign pat_bit = |(pat_q & (PAT_W'(1) << idx_q));
    // encoding 10 is unreachable but treated as S0
    assign s0      = ~ms_q[0];
    assign s1      = ms_q == 2'b01;
    assign s2      = ms_q == 2'b11;
    assign y_exp   = !((s0 && !pat_bit) || (s2 && pat_bit));
    assign ms_nxt  = !pat_bit ? (s0 ? 2'b00 : ms_q) : s0 ? 2'b01 : s1 ? 2'b11 : 2'b00;

    assign en          = state_q == STEP;
    assign a           = en ? pat_bit : a_q;
    assign busy        = state_q != IDLE;
    assign done        = state_q == FIN;
    assign err         = err_q;
    assign err_idx     = eidx_q;
    assign model_state = ms_q;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        exp_d   = exp_q;
        ms_d    = ms_q;
        err_d   = err_q;
        eidx_d  = eidx_q;
        case (state_q)
            IDLE: if (start) begin
                pat_d   = pattern;
                len_d   = len_c;
                idx_d   = '0;
                err_d   = 1'b0;
                eidx_d  = '0;
                state_d = (len_c == '0) ? FIN : STEP;
            end
            STEP: begin
                a_d     = pat_bit;
                exp_d   = y_exp;
                ms_d    = ms_nxt;
                state_d = CHECK;
            end
            CHECK: begin
                if (y_in != exp_q && !err_q) begin
                    err_d  = 1'b1;
                    eidx_d = idx_q;
                end
                idx_d   = idx_inc;
                cnt_d   = '0;
                // the last step is padded to a full STEP_DIV period before FIN
                state_d = (STEP_DIV > 2) ? GAP : (idx_inc == len_q) ? FIN : STEP;
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) state_d = (idx_q == len_q) ? FIN : STEP;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            exp_q   <= 1'b0;
            ms_q    <= 2'b00;
            err_q   <= 1'b0;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            exp_q   <= exp_d;
            ms_q    <= ms_d;
            err_q   <= err_d;
            eidx_q  <= eidx_d;
        end
    end
endmodule

// File: tb/tb_mura_driver.sv
// tb_mura_driver: directed runs of mura_driver driving a behavioural gray counter, with
// hand-computed expected step timing, y samples, model states and error reporting.
module tb_mura_driver;
    logic       clk = 1'b0;
    logic       rst_n, start, y_in, en, a, busy, done, err, fault;
    logic [7:0] pattern;
    logic [3:0] len, err_idx;
    logic [1:0] model_state, cs;
    int         n_vec = 0, n_bad = 0;
    int         r_ens, r_mask, r_done, r_y, r_ms, r_err, r_eidx, r_busy1, r_busy_after, r_err_after, r_a;

    mura_driver #(.PAT_W(8), .STEP_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len), .y_in(y_in),
        .en(en), .a(a), .busy(busy), .done(done), .err(err), .err_idx(err_idx),
        .model_state(model_state)
    );

    always #5 clk = ~clk;

    // counter under drive: S0=00 -> S1=01 -> S2=11 -> S0 on a=1 while en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs <= 2'b00;
        else if (en && a) cs <= (cs == 2'b00) ? 2'b01 : (cs == 2'b01) ? 2'b11 : 2'b00;
    end
    assign y_in = fault ? 1'b0 : (cs != 2'b00);

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic run(input logic [7:0] p, input logic [3:0] l, input int pulse_at);
        int  n;
        logic pe;
        @(negedge clk);
        pattern = p;
        len     = l;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pattern = 8'h00;
        len     = 4'd0;
        r_ens = 0; r_mask = 0; r_done = -1; r_y = 0; r_ms = 0; r_err = -1; r_eidx = -1;
        r_busy1 = int'(busy);
        pe = 1'b0;
        n  = 0;
        for (int c = 1; c < 60; c++) begin
            if (pe) begin
                r_y  |= int'(y_in) << n;
                r_ms |= int'(model_state) << (2 * n);
                n++;
            end
            pe = en;
            if (en) begin
                r_ens++;
                r_mask |= 1 << c;
            end
            start = (c == pulse_at);
            if (done) begin
                r_done = c;
                r_err  = int'(err);
                r_eidx = int'(err_idx);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        start        = 1'b0;
        r_busy_after = int'(busy);
        r_err_after  = int'(err);
        r_a          = int'(a);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; start = 1'b0; pattern = 8'h00; len = 4'd0; fault = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_en", en, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ms", model_state, 0);
        rst_n = 1'b1;

        run(8'b111, 4'd3, -1);
        check("cnt_en_mask", r_mask, 32'h2A);
        check("cnt_done", r_done, 7);
        check("cnt_y", r_y, 3'b011);
        check("cnt_ms", r_ms, 6'b00_11_01);
        check("cnt_err", r_err, 0);
        check("cnt_busy1", r_busy1, 1);
        check("cnt_busy_after", r_busy_after, 0);
        check("cnt_a_hold", r_a, 1);

        run(8'b00, 4'd2, 5);
        check("hold0_en_mask", r_mask, 32'hA);
        check("hold0_done", r_done, 5);
        check("hold0_y", r_y, 0);
        check("hold0_ms", r_ms, 0);
        check("start_in_done_ignored", r_busy_after, 0);

        run(8'b01, 4'd2, -1);
        check("hold1_y", r_y, 2'b11);
        check("hold1_ms", r_ms, 4'b01_01);
        check("hold1_err", r_err, 0);

        fault = 1'b1;
        run(8'b0101, 4'd4, -1);
        check("f1_done", r_done, 9);
        check("f1_err", r_err, 1);
        check("f1_eidx", r_eidx, 0);
        check("f1_err_hold", r_err_after, 1);
        check("f1_ms_end", model_state, 2'b00);

        run(8'b0110, 4'd4, -1);
        check("f2_err", r_err, 1);
        check("f2_eidx", r_eidx, 1);
        check("f2_ens", r_ens, 4);
        fault = 1'b0;

        run(8'hFF, 4'd0, -1);
        check("len0_done", r_done, 1);
        check("len0_ens", r_ens, 0);
        check("len0_busy1", r_busy1, 1);
        check("len0_busy_after", r_busy_after, 0);
        check("len0_err_clr", r_err, 0);
        check("len0_eidx_clr", r_eidx, 0);
        check("len0_ms", model_state, 2'b11);

        run(8'hFF, 4'd15, 4);
        check("clamp_ens", r_ens, 8);
        check("clamp_done", r_done, 17);
        check("clamp_y", r_y, 8'hB6);
        check("clamp_ms", r_ms, 16'h4D34);
        check("clamp_err", r_err, 0);

        @(negedge clk);
        pattern = 8'b001;
        len     = 4'd4;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_en", en, 1);
        check("pre_rst_ms", model_state, 2'b11);
        rst_n = 1'b0;
        #1;
        check("async_en", en, 0);
        check("async_busy", busy, 0);
        check("async_ms", model_state, 0);
        check("async_a", a, 0);
        check("async_done", done, 0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            dn += int'(done);
        end
        check("rst_no_done", dn, 0);

        run(8'b11, 4'd2, -1);
        check("post_rst_y", r_y, 2'b11);
        check("post_rst_ms", r_ms, 4'b11_01);
        check("post_rst_err", r_err, 0);
        check("post_rst_done", r_done, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
